// File: rtl/cpu6_memarb.sv
// cpu6_memarb: one shared memory bus between instruction fetch and MEM-stage data.
// One transaction at a time; the owner gets a single-cycle done pulse.
module cpu6_memarb #(
  parameter int XLEN        = 32,
  parameter int MAX_DSTREAK = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_done,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_done,
  output logic [XLEN-1:0] d_rdata,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [2:0] STREAK_MAX = 3'(MAX_DSTREAK);
  localparam logic [2:0] STREAK_SAT = 3'd7;

  state_e          state_r, nextState_s;
  logic [2:0]      dStreak_r, nextStreak_s;
  logic            busReq_r, nextBusReq_s;
  logic            busWe_r, nextBusWe_s;
  logic [XLEN-1:0] busAddr_r, nextBusAddr_s;
  logic [XLEN-1:0] busWdata_r, nextBusWdata_s;
  logic            ifDone_r, nextIfDone_s;
  logic            dDone_r, nextDDone_s;
  logic [XLEN-1:0] ifRdata_r, nextIfRdata_s;
  logic [XLEN-1:0] dRdata_r, nextDRdata_s;
  logic            dataWins_s;

  // Data goes first unless a waiting fetch has already sat out MAX_DSTREAK data grants.
  assign dataWins_s = d_req && !(if_req && (dStreak_r == STREAK_MAX));

  // Next-state, grant and capture logic; bus_ready only matters in the bus states.
  always_comb begin
    nextState_s    = state_r;
    nextStreak_s   = dStreak_r;
    nextBusReq_s   = busReq_r;
    nextBusWe_s    = busWe_r;
    nextBusAddr_s  = busAddr_r;
    nextBusWdata_s = busWdata_r;
    nextIfDone_s   = 1'b0;
    nextDDone_s    = 1'b0;
    nextIfRdata_s  = ifRdata_r;
    nextDRdata_s   = dRdata_r;
    case (state_r)
      IDLE: begin
        if (dataWins_s) begin
          nextState_s    = BUS_D;
          nextBusReq_s   = 1'b1;
          nextBusWe_s    = d_we;
          nextBusAddr_s  = d_addr;
          nextBusWdata_s = d_wdata;
          if (if_req) begin
            nextStreak_s = (dStreak_r == STREAK_SAT) ? dStreak_r : dStreak_r + 3'd1;
          end else begin
            nextStreak_s = 3'd0;
          end
        end else if (if_req) begin
          nextState_s    = BUS_I;
          nextBusReq_s   = 1'b1;
          nextBusWe_s    = 1'b0;
          nextBusAddr_s  = if_addr;
          nextBusWdata_s = {XLEN{1'b0}};
          nextStreak_s   = 3'd0;
        end else begin
          nextState_s = IDLE;
        end
      end
      BUS_I: begin
        if (bus_ready) begin
          nextState_s   = DONE;
          nextBusReq_s  = 1'b0;
          nextIfDone_s  = 1'b1;
          nextIfRdata_s = bus_rdata;
        end else begin
          nextState_s = BUS_I;
        end
      end
      BUS_D: begin
        if (bus_ready) begin
          nextState_s  = DONE;
          nextBusReq_s = 1'b0;
          nextDDone_s  = 1'b1;
          // A store leaves the last load result in place.
          if (!busWe_r) begin
            nextDRdata_s = bus_rdata;
          end else begin
            nextDRdata_s = dRdata_r;
          end
        end else begin
          nextState_s = BUS_D;
        end
      end
      DONE: begin
        nextState_s = IDLE;
      end
      default: begin
        nextState_s  = IDLE;
        nextBusReq_s = 1'b0;
      end
    endcase
  end

  // State and all registered outputs; reset also drops any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= IDLE;
      dStreak_r  <= 3'd0;
      busReq_r   <= 1'b0;
      busWe_r    <= 1'b0;
      busAddr_r  <= {XLEN{1'b0}};
      busWdata_r <= {XLEN{1'b0}};
      ifDone_r   <= 1'b0;
      dDone_r    <= 1'b0;
      ifRdata_r  <= {XLEN{1'b0}};
      dRdata_r   <= {XLEN{1'b0}};
    end else begin
      state_r    <= nextState_s;
      dStreak_r  <= nextStreak_s;
      busReq_r   <= nextBusReq_s;
      busWe_r    <= nextBusWe_s;
      busAddr_r  <= nextBusAddr_s;
      busWdata_r <= nextBusWdata_s;
      ifDone_r   <= nextIfDone_s;
      dDone_r    <= nextDDone_s;
      ifRdata_r  <= nextIfRdata_s;
      dRdata_r   <= nextDRdata_s;
    end
  end

  assign bus_req   = busReq_r;
  assign bus_we    = busWe_r;
  assign bus_addr  = busAddr_r;
  assign bus_wdata = busWdata_r;
  assign if_done   = ifDone_r;
  assign d_done    = dDone_r;
  assign if_rdata  = ifRdata_r;
  assign d_rdata   = dRdata_r;

endmodule

// File: doc/cpu6_memarb.md
# cpu6_memarb

Single-port memory arbiter for cpu6. It shares one memory bus between the instruction-fetch requester and the MEM-stage data requester, which drives `dataaddrM`, `writedataM` and `memwriteM`. The FSM registers one transaction at a time and returns a one-cycle completion pulse to the owning requester. Data has priority over fetch, bounded by a starvation limit. The block sits between the cpu6 core and the shared memory/bus.

## Interface
- `XLEN`, default 32: address/data width, equal to `CPU6_XLEN`.
- `MAX_DSTREAK`, default 2: maximum consecutive data grants while a fetch is waiting. Legal range is 1..7.

- `clk` input 1: the single clock. All state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `if_req` input 1: fetch request. Held high until `if_done`.
- `if_addr` input XLEN: fetch address. Stable while `if_req` is high.
- `if_done` output 1: one-cycle completion pulse for a fetch.
- `if_rdata` output XLEN: fetched instruction. Valid when `if_done` is high; holds its value otherwise.
- `d_req` input 1: data request. Held high until `d_done`.
- `d_we` input 1: 1 = store, 0 = load. Stable while `d_req` is high.
- `d_addr` input XLEN: data address.
- `d_wdata` input XLEN: store data.
- `d_done` output 1: one-cycle completion pulse for a data access.
- `d_rdata` output XLEN: load data. Valid when `d_done` is high for a load.
- `bus_req` output 1: bus transaction active.
- `bus_we` output 1: bus write enable.
- `bus_addr` output XLEN: bus address.
- `bus_wdata` output XLEN: bus write data.
- `bus_ready` input 1: memory has completed the transaction. Sampled only while `bus_req` is high.
- `bus_rdata` input XLEN: read data. Valid with `bus_ready`.

## Operation
- The FSM has four states: IDLE, BUS_I, BUS_D, DONE.
- **IDLE**
  - If `d_req` is high and the data requester wins the grant rule, go to BUS_D. Latch `bus_addr`=`d_addr`, `bus_we`=`d_we` and `bus_wdata`=`d_wdata`.
  - Otherwise, if `if_req` is high, go to BUS_I. Latch `bus_addr`=`if_addr`, `bus_we`=0, `bus_wdata`=0.
  - Otherwise stay in IDLE.
- **Grant rule:** data wins unless `if_req` is also high and `dstreak`==`MAX_DSTREAK`.
- **`dstreak` counter** (3-bit, saturating):
  - Increments on a data grant made while `if_req` is high.
  - Clears on any fetch grant.
  - Clears on a data grant made while `if_req` is low.
- **BUS_I / BUS_D**
  - `bus_req`=1. `bus_addr`, `bus_we` and `bus_wdata` are registered and held stable.
  - On `bus_ready`=1, go to DONE. Capture `bus_rdata` into `if_rdata` (fetch) or into `d_rdata` (data load only).
  - `d_rdata` is unchanged by a store.
  - The owner's `*_done` is registered high for the DONE cycle.
- **DONE**
  - Exactly one `*_done` is high.
  - All requests are ignored in this cycle, because the requester is still dropping `req`.
  - Always go to IDLE next.
- Only one transaction is outstanding at a time. There is no pipelining and no abort.
- A requester that drops `req` before its `done` is a protocol violation. The arbiter completes the bus transaction anyway.

## Timing
- **Reset values:** state IDLE; `dstreak`=0; `bus_req`=0, `bus_we`=0, `bus_addr`=0, `bus_wdata`=0; `if_done`=0, `d_done`=0, `if_rdata`=0, `d_rdata`=0.
- **Reset mid-transaction:** the FSM returns to IDLE at that edge and `bus_req` drops. No `done` pulse is produced, and captured data is cleared.
- **Latency:**
  - A request sampled in IDLE at edge N gives `bus_req`=1 in cycle N+1.
  - `bus_ready` sampled at edge M gives `*_done` high in cycle M+1. That cycle is DONE.
  - The next request can be sampled at edge M+2, so `bus_req` is high again in cycle M+3.
  - With `bus_ready` tied high, a lone requester gets a transaction every 3 cycles. The minimum latency from request to `done` is 3 cycles.
- **Simultaneous `if_req` and `d_req` in IDLE:** the grant rule decides. The loser stays pending and is granted on the next IDLE visit.
- **`bus_ready` while `bus_req` is low:** ignored.
- **Width rules:** all data paths are XLEN bits. Nothing is extended or truncated.
- **Starvation bound:** with `MAX_DSTREAK`=2 and both requesters held continuously, the grant order is D, D, I, D, D, I, and so on.

## Test plan
1. **Lone fetch:** assert reset for 2 cycles, then `if_req`=1 with `if_addr`=0x100 and `bus_ready` tied high returning 0x00500093. Require `bus_req` with `bus_addr`=0x100 and `bus_we`=0 one cycle after the request, then `if_done` pulsing with `if_rdata`=0x00500093 in the third cycle.
2. **Store then load:** store `d_we`=1, `d_addr`=0x2000, `d_wdata`=0xDEADBEEF, then a load from 0x2000 with a bus model returning 0xDEADBEEF. Require `bus_we`=1 and `bus_wdata`=0xDEADBEEF on the first transaction, `d_rdata` unchanged at its store `d_done`, and `d_rdata`=0xDEADBEEF at the load's `d_done`.
3. **Starvation bound:** hold `if_req` and `d_req` continuously for 9 transactions with `MAX_DSTREAK`=2. Require the grant sequence D,D,I,D,D,I,D,D,I.
4. **Bus wait states:** use `bus_ready` low for 4 cycles on a data read of 0x40. Require `bus_req`, `bus_addr`=0x40 and `bus_we`=0 to stay stable for all 5 bus cycles, and exactly one `d_done` pulse.
5. **Reset mid-transaction:** assert `reset` during BUS_D. Require `bus_req`=0, `d_done`=0 and `d_rdata`=0 the next cycle, then a normal grant after reset is released.
6. **DONE-cycle rule:** hold `d_req` high through its own `d_done` cycle. Require no re-grant in the DONE cycle. A re-grant occurs only if `d_req` is still high in IDLE, which models a back-to-back request.
